// File: rtl/load_buffer.sv
// Buffers words captured while the upstream load FSM is in LOAD and keeps their running sum.
// Once READY is seen, it streams the words out in arrival order over valid/ready and then raises done.
module load_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [1:0]        state,
    input  logic              load,
    input  logic [DW-1:0]     data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [CW-1:0]     count,
    output logic [DW+CW-1:0]  sum,
    output logic              overflow,
    output logic              done,
    output logic [1:0]        dbg_phase
);

    // Handshake: a word moves on a rising edge where out_valid && out_ready.
    // While out_valid is high and out_ready is low, out_data, out_last and out_valid hold.

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        PH_FILL  = 2'd0,
        PH_DRAIN = 2'd1,
        PH_END   = 2'd2
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DW+CW-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               mem_we;
    logic               capture;
    logic               slot_free;

    logic [DW-1:0] mem [DEPTH];

    assign capture   = (state == 2'b01) && load;
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        phase_d     = phase_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        done_d      = done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        mem_we      = 1'b0;
        case (phase_q)
            PH_FILL: begin
                if (state == 2'b10) begin
                    phase_d = PH_DRAIN;
                end else if (capture) begin
                    if (count_q < DEPTH_C) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                        sum_d   = sum_q + (DW+CW)'(data_in);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            PH_DRAIN: begin
                if (slot_free) begin
                    if (rd_ptr_q < count_q) begin
                        out_data_d  = mem[rd_ptr_q[AW-1:0]];
                        out_valid_d = 1'b1;
                        out_last_d  = (rd_ptr_q == count_q - 1'b1);
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                    end else begin
                        // Last word already accepted (or nothing was stored): finish.
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        phase_d     = PH_END;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            phase_q     <= PH_FILL;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign count     = count_q;
    assign sum       = sum_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign dbg_phase = phase_q;

endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer: a queue-based reference of captured words predicts count,
// sum, overflow and the drained stream, and a negedge monitor checks every handshake.
module tb_load_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic [1:0]       state = 2'b00;
    logic             load = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [CW-1:0]    count;
    logic [DW+CW-1:0] sum;
    logic             overflow;
    logic             done;
    logic [1:0]       dbg_phase;

    load_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .srst_n(srst_n), .state(state), .load(load), .data_in(data_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .count(count), .sum(sum), .overflow(overflow), .done(done), .dbg_phase(dbg_phase)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW:0] exp_q[$];   // {last, data}
    int          stim[$];    // words offered for capture in the next fill
    int          words[$];   // every word the model saw captured (including dropped ones)
    int          hs_cnt = 0;
    bit          last_seen = 0;
    bit          stall_prev = 0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [DW:0]   e_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!srst_n) begin
            stall_prev = 0;
            last_seen  = 0;
        end else begin
            if (last_seen) begin
                check("done_after_last", done, 1);
                last_seen = 0;
            end
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, stall_data);
                check("hold_last", out_last, stall_last);
            end
            stall_prev = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", out_valid, 0);
                    end else begin
                        e_w = exp_q.pop_front();
                        check("out_data", out_data, e_w[DW-1:0]);
                        check("out_last", out_last, e_w[DW]);
                        check("done_early", done, 0);
                        hs_cnt++;
                        if (out_last) last_seen = 1;
                    end
                end else begin
                    stall_prev = 1;
                    stall_data = out_data;
                    stall_last = out_last;
                end
            end
        end
    end

    // reference model
    function automatic int m_count();
        return (words.size() < DEPTH) ? words.size() : DEPTH;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < m_count(); i++) s += words[i];
        return s;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_count"}, count, m_count());
        check({tag, "_sum"}, sum, m_sum());
        check({tag, "_overflow"}, overflow, (words.size() > DEPTH) ? 1 : 0);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst_n = 1'b0;
        state = 2'b00;
        load = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_count", count, 0);
        check("rst_sum", sum, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        words.delete();
        srst_n = 1'b1;
    endtask

    task automatic fill(input bit gaps);
        for (int i = 0; i < stim.size(); i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                data_in = DW'($urandom);
                if ($urandom_range(0, 1) == 0) begin
                    state = 2'b01;
                    load = 1'b0;
                end else begin
                    state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    load = 1'b1;
                end
                tick();
                check_model("gap");
            end
            state = 2'b01;
            load = 1'b1;
            data_in = DW'(stim[i]);
            words.push_back(stim[i]);
            tick();
            check_model("fill");
        end
        load = 1'b0;
    endtask

    task automatic drain(input int rmode);
        bit [7:0] pat = 8'b1110_1001;
        int m = m_count();
        bit finished = 0;
        for (int i = 0; i < m; i++) exp_q.push_back({(i == m - 1), DW'(words[i])});
        state = 2'b10;
        load = 1'($urandom);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = pat[cyc % 8];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc > 0) begin
                state = 2'($urandom_range(0, 3));
                load = 1'($urandom);
                data_in = DW'($urandom);
            end
            tick();
            if (done) finished = 1;
        end
        check("drain_done", done, 1);
        check("drain_valid_low", out_valid, 0);
        check_model("drain");
        check("exp_q_empty", exp_q.size(), 0);
        state = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        int guard;
        tick();

        // basic
        stim = '{3, 7, 1, 9, 2};
        do_reset();
        fill(0);
        check("basic_count", count, 5);
        check("basic_sum", sum, 22);
        drain(0);
        check("basic_overflow", overflow, 0);

        // backpressure
        do_reset();
        fill(0);
        hs_cnt = 0;
        drain(1);
        check("bp_handshakes", hs_cnt, 5);

        // overflow
        stim.delete();
        for (int i = 1; i <= 18; i++) stim.push_back(i);
        do_reset();
        fill(0);
        check("ovf_count", count, 16);
        check("ovf_sum", sum, 136);
        check("ovf_flag", overflow, 1);
        drain(0);

        // width: 16 x FF then a 17th
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(255);
        do_reset();
        fill(0);
        check("width_sum", sum, 4080);
        check("width_overflow0", overflow, 0);
        stim = '{255};
        fill(0);
        check("width_sum_held", sum, 4080);
        check("width_overflow1", overflow, 1);
        drain(2);

        // empty
        do_reset();
        out_ready = 1'b1;
        state = 2'b01;
        load = 1'b0;
        tick();
        state = 2'b10;
        tick();
        check("empty_done_edge1", done, 0);
        tick();
        check("empty_done_edge2", done, 1);
        check("empty_valid", out_valid, 0);
        check("empty_count", count, 0);
        check("empty_sum", sum, 0);
        state = 2'b00;
        tick();

        // reset mid-drain
        stim = '{3, 7, 1, 9, 2};
        do_reset();
        fill(0);
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), DW'(words[i])});
        hs_cnt = 0;
        state = 2'b10;
        out_ready = 1'b1;
        guard = 0;
        while (hs_cnt < 2 && guard < 50) begin
            tick();
            guard++;
        end
        check("mid_drain_reached", (hs_cnt >= 2) ? 1 : 0, 1);
        do_reset();
        stim = '{4, 5, 6};
        fill(0);
        check("after_rst_sum", sum, 15);
        drain(0);

        // randomized
        for (int t = 0; t < 8; t++) begin
            stim.delete();
            for (int i = 0; i < $urandom_range(0, 20); i++) stim.push_back($urandom_range(0, 255));
            do_reset();
            fill(1);
            drain(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- Datapath stage directly downstream of the load-control FSM; consumes its 2-bit `state` and the shared `load` strobe.
- While the FSM is in LOAD with `load` high, captures one input word per cycle into a local buffer and keeps a running sum.
- Once the FSM reaches READY, streams the captured words out in arrival order over a valid/ready interface, then flags completion.

Parameters:
- DW, 8, data word width.
- DEPTH, 16, buffer capacity in words.
- CW, 5, count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- srst_n  input  1  reset; synchronous, active-low.
- state  input  2  FSM state: 2'b00 IDLE, 2'b01 LOAD, 2'b10 READY; 2'b11 is treated as IDLE.
- load  input  1  data-present strobe, same signal that drives the FSM.
- data_in  input  DW  word captured when a capture condition holds.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- out_valid  output  1  `out_data` holds a valid buffered word.
- out_data  output  DW  buffered word being presented.
- out_last  output  1  high with `out_valid` on the final word.
- count  output  CW  number of words stored.
- sum  output  DW+CW  unsigned sum of stored words; cannot overflow.
- overflow  output  1  sticky; a word was dropped because the buffer was full.
- done  output  1  sticky; drain complete.

Behaviour:
- Reset (`srst_n` = 0 at a clock edge):
  - Clears all outputs, `count`, `sum`, the read pointer, and `phase`; `phase` returns to FILL.
  - Buffer RAM is not reset.
  - Reset mid-fill or mid-drain aborts immediately.
- Internal `phase` register: FILL → DRAIN → END.
  - FILL: capture enabled.
  - FILL → DRAIN on the first edge where `state` == 2'b10.
  - DRAIN → END on the edge that completes the drain.
  - END holds until reset; `state` is ignored outside FILL.
- Capture condition: `phase` == FILL, `state` == 2'b01, and `load` == 1.
  - If `count` < DEPTH: `mem[count]` ← `data_in`, `count` += 1, `sum` += `data_in` (zero-extended), all at the same edge.
  - If `count` == DEPTH: word dropped; `overflow` ← 1; `count` and `sum` unchanged.
  - `state` == 2'b00 or 2'b11, or `load` == 0: no capture.
- Drain, with `out_valid`, `out_data`, `out_last` all registered:
  - Presentation slot is free when `out_valid` == 0, or `out_valid` && `out_ready` (handshake).
  - In DRAIN with a free slot and `rd_ptr` < `count`: `out_data` ← `mem[rd_ptr]`, `out_valid` ← 1, `out_last` ← (`rd_ptr` == `count`-1), `rd_ptr` += 1.
  - In DRAIN with a free slot and `rd_ptr` == `count`: `out_valid` ← 0, `out_last` ← 0, `done` ← 1, `phase` ← END.
- Drain timing:
  - Latency: the first READY cycle moves `phase` to DRAIN. The first `out_valid` rises one edge after that; with continuous `out_ready`, one word per cycle follows.
  - Backpressure: while `out_valid` && !`out_ready`, `out_data`, `out_last`, and `out_valid` hold stable.
  - `done` rises on the edge after the final handshake.
- Zero words captured: `out_valid` never asserts; `done` rises two edges after the first READY edge.
- `count`, `sum`, and `overflow` stay frozen after FILL and remain readable during DRAIN and END.

Test Plan:
- Basic: reset, then `load` = 1 for 5 cycles with `data_in` 3, 7, 1, 9, 2, then `load` = 0; `out_ready` = 1. Expect:
  - `count` = 5, `sum` = 22.
  - Outputs 3, 7, 1, 9, 2 on consecutive cycles with `out_last` only on 2.
  - `done` = 1 on the next edge; `overflow` = 0.
- Backpressure: same load, `out_ready` pattern 1,0,0,1,0,1,1,1. Expect `out_data` held across every stalled cycle, no word lost or duplicated, and `out_last` on the 5th handshake only.
- Overflow: 18 words 1..18. Expect `count` = 16, `overflow` = 1, `sum` = 136, only 1..16 streamed, and `out_last` on 16.
- Empty: `load` held 0 after reset; FSM passes LOAD for one cycle into READY. Expect no `out_valid`, `done` = 1 two edges after the first READY cycle, and `count` = 0, `sum` = 0.
- Width: 16 words of 8'hFF. Expect `sum` = 13'd4080 and `overflow` = 0; a 17th word sets `overflow` with `sum` unchanged.
- Reset mid-drain: assert `srst_n` = 0 after the 2nd handshake. Expect all outputs 0 on the next edge; a following 3-word load of 4, 5, 6 streams exactly 4, 5, 6 with `sum` = 15.
